// File: rtl/vector_pkg.sv
// Shared constants and types for the vector datapath memory unit.
// LANES is also consumed by the lane ALUs, so it lives here rather than in the unit.
package vector_pkg;

  localparam int N     = 8;
  localparam int LANES = 6;
  localparam int AW    = 16;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    DRAIN,
    DONE
  } vmem_state_t;

  typedef logic [LANES-1:0][N-1:0] lane_vec_t;

endpackage

// File: rtl/vmem_addr_gen.sv
// Lane counter plus base+lane address adder for vector memory transfers.
// The counter saturates at LANES-1 so it never indexes past the last lane.
module vmem_addr_gen
  import vector_pkg::*;
#(
  parameter int LANES = vector_pkg::LANES,
  parameter int AW    = vector_pkg::AW,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  input  logic [AW-1:0] base,
  output logic [LW-1:0] lane,
  output logic [AW-1:0] addr,
  output logic          last
);

  assign last = (lane == LW'(LANES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (inc && !last) begin
      lane <= lane + LW'(1);
    end
  end

  // Truncation to AW bits gives the modulo-2^AW wrap for free.
  assign addr = base + AW'(lane);

endmodule

// File: rtl/vector_mem_unit.sv
// Memory end of the vector datapath: serializes vector stores into LANES byte writes and
// assembles LANES byte reads into one vector, stalling the pipeline while a transfer runs.
module vector_mem_unit
  import vector_pkg::*;
#(
  parameter int N     = vector_pkg::N,
  parameter int LANES = vector_pkg::LANES,
  parameter int AW    = vector_pkg::AW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    StartM,
  input  logic                    MemWriteM,
  input  logic [AW-1:0]           BaseAddrM,
  input  logic [LANES-1:0][N-1:0] StoreDataM,
  input  logic [N-1:0]            MemRData,
  output logic [AW-1:0]           MemAddr,
  output logic                    MemWE,
  output logic [N-1:0]            MemWData,
  output logic                    BusyM,
  output logic                    DoneM,
  output logic [LANES-1:0][N-1:0] LoadDataM
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  vmem_state_t             state;
  vmem_state_t             state_next;
  logic [AW-1:0]           base;
  logic [AW-1:0]           addr_hold;
  logic [AW-1:0]           lane_addr;
  logic [N-1:0]            wdata_hold;
  logic [LANES-1:0][N-1:0] store_vec;
  logic [LANES-1:0][N-1:0] shadow;
  logic [LANES-1:0][N-1:0] shadow_next;
  logic [LW-1:0]           lane;
  logic [LW-1:0]           cap_lane;
  logic                    lane_last;
  logic                    start;
  logic                    active;
  logic                    ctr_inc;
  logic                    capture;

  assign start   = (state == IDLE) && StartM;
  assign active  = (state == STORE) || (state == LOAD);
  assign ctr_inc = active && !lane_last;

  vmem_addr_gen #(
    .LANES(LANES),
    .AW   (AW),
    .LW   (LW)
  ) u_addr_gen (
    .clk  (clk),
    .reset(reset),
    .clear(start),
    .inc  (ctr_inc),
    .base (base),
    .lane (lane),
    .addr (lane_addr),
    .last (lane_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (StartM) state_next = MemWriteM ? STORE : LOAD;
      STORE:   if (lane_last) state_next = DONE;
      LOAD:    if (lane_last) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so each LOAD cycle captures the previous lane
  // and DRAIN picks up the last one (the counter has saturated there).
  always_comb begin
    shadow_next = shadow;
    capture     = 1'b0;
    cap_lane    = lane;
    if (state == DRAIN) begin
      capture = 1'b1;
    end else if ((state == LOAD) && (lane != '0)) begin
      capture  = 1'b1;
      cap_lane = lane - LW'(1);
    end
    if (capture) begin
      shadow_next[cap_lane] = MemRData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base       <= '0;
      store_vec  <= '0;
      shadow     <= '0;
      LoadDataM  <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      if (start) begin
        base      <= BaseAddrM;
        store_vec <= StoreDataM;
      end
      if (active) begin
        addr_hold <= lane_addr;
      end
      if (state == STORE) begin
        wdata_hold <= store_vec[lane];
      end
      shadow <= shadow_next;
      // Publishing the whole vector on entry to DONE keeps partial loads invisible.
      if (state == DRAIN) begin
        LoadDataM <= shadow_next;
      end
    end
  end

  assign BusyM    = (state != IDLE);
  assign DoneM    = (state == DONE);
  assign MemWE    = (state == STORE);
  assign MemAddr  = active ? lane_addr : addr_hold;
  assign MemWData = (state == STORE) ? store_vec[lane] : wdata_hold;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Self-checking bench for vector_mem_unit: directed and random transfers against a
// byte-array memory and a lane-by-lane reference model of stores and loads.
module tb_vector_mem_unit;
  import vector_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        StartM;
  logic        MemWriteM;
  logic [15:0] BaseAddrM;
  lane_vec_t   StoreDataM;
  logic [7:0]  MemRData;
  logic [15:0] MemAddr;
  logic        MemWE;
  logic [7:0]  MemWData;
  logic        BusyM;
  logic        DoneM;
  lane_vec_t   LoadDataM;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [65536];
  logic [7:0] ref_mem [65536];
  lane_vec_t  exp_load;

  logic [15:0] wr_addr  [$];
  logic [7:0]  wr_data  [$];
  int          wr_cycle [$];
  int          done_cycle;
  int          busy_cycles;
  lane_vec_t   load_at_done;
  lane_vec_t   load_before_done;
  logic [15:0] stored_bases [$];

  always #5 clk = ~clk;

  vector_mem_unit dut (
    .clk       (clk),
    .reset     (reset),
    .StartM    (StartM),
    .MemWriteM (MemWriteM),
    .BaseAddrM (BaseAddrM),
    .StoreDataM(StoreDataM),
    .MemRData  (MemRData),
    .MemAddr   (MemAddr),
    .MemWE     (MemWE),
    .MemWData  (MemWData),
    .BusyM     (BusyM),
    .DoneM     (DoneM),
    .LoadDataM (LoadDataM)
  );

  // Single-port byte memory with one cycle of read latency.
  always @(posedge clk) begin
    if (MemWE) mem[MemAddr] <= MemWData;
    MemRData <= mem[MemAddr];
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer starting on the next cycle; optionally pokes StartM in cycle 3.
  task automatic applyStimulus(input logic wr, input logic [15:0] base, input lane_vec_t data,
                               input bit poke);
    wr_addr.delete();
    wr_data.delete();
    wr_cycle.delete();
    done_cycle       = -1;
    busy_cycles      = 0;
    load_at_done     = '0;
    load_before_done = '0;
    @(negedge clk);
    checkVal("idle_busy_before_start", BusyM, 1'b0);
    checkVal("idle_done_before_start", DoneM, 1'b0);
    StartM     = 1'b1;
    MemWriteM  = wr;
    BaseAddrM  = base;
    StoreDataM = data;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (MemWE) begin
        wr_addr.push_back(MemAddr);
        wr_data.push_back(MemWData);
        wr_cycle.push_back(c);
      end
      if (BusyM) busy_cycles++;
      if (DoneM) begin
        done_cycle   = c;
        load_at_done = LoadDataM;
      end else begin
        load_before_done = LoadDataM;
      end
      StartM = poke && (c == 3);
      if (StartM) begin
        MemWriteM  = ~wr;
        BaseAddrM  = base ^ 16'h0100;
        StoreDataM = ~data;
      end
      if (done_cycle > 0) break;
    end
    StartM = 1'b0;
  endtask

  task automatic checkOutput(input logic wr, input logic [15:0] base, input lane_vec_t data);
    int        exp_done;
    int        n;
    lane_vec_t v;
    logic [15:0] a;
    exp_done = wr ? 7 : 8;
    checkVal("done_cycle", done_cycle, exp_done);
    checkVal("busy_cycles", busy_cycles, exp_done);
    if (wr) begin
      checkVal("write_count", wr_addr.size(), 6);
      n = (wr_addr.size() < 6) ? wr_addr.size() : 6;
      for (int k = 0; k < n; k++) begin
        a = 16'((int'(base) + k) % 65536);
        checkVal($sformatf("write_addr[%0d]", k), wr_addr[k], a);
        checkVal($sformatf("write_data[%0d]", k), wr_data[k], data[k]);
        checkVal($sformatf("write_cycle[%0d]", k), wr_cycle[k], k + 1);
      end
      for (int k = 0; k < 6; k++) ref_mem[(int'(base) + k) % 65536] = data[k];
      stored_bases.push_back(base);
      checkVal("load_held_over_store", load_at_done, exp_load);
    end else begin
      checkVal("write_count_on_load", wr_addr.size(), 0);
      for (int k = 0; k < 6; k++) v[k] = ref_mem[(int'(base) + k) % 65536];
      checkVal("load_before_done", load_before_done, exp_load);
      exp_load = v;
      checkVal("load_at_done", load_at_done, exp_load);
    end
  endtask

  initial begin
    lane_vec_t   d;
    logic        wr;
    logic [15:0] b;
    int          pulses;

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    exp_load   = '0;
    reset      = 1'b1;
    StartM     = 1'b0;
    MemWriteM  = 1'b0;
    BaseAddrM  = '0;
    StoreDataM = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkVal("reset_busy", BusyM, 1'b0);
      checkVal("reset_done", DoneM, 1'b0);
      checkVal("reset_we", MemWE, 1'b0);
      checkVal("reset_load", LoadDataM, '0);
      checkVal("reset_addr", MemAddr, 16'h0000);
    end

    d = {8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    applyStimulus(1'b1, 16'h0010, d, 1'b0);
    checkOutput(1'b1, 16'h0010, d);
    applyStimulus(1'b0, 16'h0010, '0, 1'b0);
    checkOutput(1'b0, 16'h0010, '0);
    checkVal("directed_load_value", load_at_done, 48'h060504030201);

    d = {8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1};
    applyStimulus(1'b1, 16'h0030, d, 1'b0);
    checkOutput(1'b1, 16'h0030, d);

    d = {8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31};
    applyStimulus(1'b1, 16'hFFFD, d, 1'b0);
    checkOutput(1'b1, 16'hFFFD, d);
    checkVal("wrap_addr3", wr_addr.size() > 3 ? wr_addr[3] : 16'hDEAD, 16'h0000);

    d = {8'h46, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41};
    applyStimulus(1'b1, 16'h0040, d, 1'b1);
    checkOutput(1'b1, 16'h0040, d);

    applyStimulus(1'b0, 16'hFFFD, '0, 1'b0);
    checkOutput(1'b0, 16'hFFFD, '0);

    // Reset in cycle 4 of a load.
    @(negedge clk);
    StartM    = 1'b1;
    MemWriteM = 1'b0;
    BaseAddrM = 16'h0010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      StartM = 1'b0;
    end
    checkVal("busy_before_reset", BusyM, 1'b1);
    reset = 1'b1;
    #1;
    checkVal("midreset_we", MemWE, 1'b0);
    checkVal("midreset_busy", BusyM, 1'b0);
    checkVal("midreset_load", LoadDataM, '0);
    exp_load = '0;
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (DoneM) pulses++;
    end
    checkVal("midreset_no_done", pulses, 0);
    applyStimulus(1'b0, 16'h0040, '0, 1'b0);
    checkOutput(1'b0, 16'h0040, '0);

    for (int t = 0; t < 12; t++) begin
      wr = 1'($urandom_range(0, 1));
      for (int k = 0; k < 6; k++) d[k] = 8'($urandom);
      if (!wr && (stored_bases.size() > 0) && ($urandom_range(0, 2) != 0))
        b = stored_bases[$urandom_range(0, stored_bases.size() - 1)] + 16'($urandom_range(0, 3));
      else if ($urandom_range(0, 3) == 0)
        b = 16'hFFFA + 16'($urandom_range(0, 5));
      else
        b = 16'($urandom);
      applyStimulus(wr, b, d, $urandom_range(0, 3) == 0);
      checkOutput(wr, b, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
